// File: rtl/dict_decompressor_pkg.sv
// Shared types and code-word field helpers for the dictionary decompressor.
package decomp_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CODE_RD  = 3'd1,
    ST_DECODE   = 3'd2,
    ST_RAW_RD   = 3'd3,
    ST_RAW_WAIT = 3'd4,
    ST_RESP     = 3'd5
  } decomp_state_t;

  // Which path produced the response held in RESP; decides which counter moves.
  typedef enum logic [1:0] {
    KIND_ERR = 2'd0,
    KIND_HIT = 2'd1,
    KIND_RAW = 2'd2
  } decomp_kind_t;

  // Tag bit sits directly above the index field.
  function automatic int code_tag_pos(input int idx_w);
    return idx_w;
  endfunction

  // Most significant bit of the index field; the field always starts at bit 0.
  function automatic int code_idx_msb(input int idx_w);
    return idx_w - 1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dict_decompressor_if.sv
// Fetch-side, memory-side and dictionary-load signals of the decompressor.
interface dict_decompressor_if
  import decomp_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int IDX_W   = 8
);
  logic               req_valid;
  logic               req_ready;
  logic [PC_W-1:0]    req_pc;
  logic               resp_valid;
  logic               resp_ready;
  logic [INSTR_W-1:0] resp_instr;
  logic               resp_err;
  logic               code_re;
  logic [PC_W-1:0]    code_addr;
  logic [IDX_W:0]     code_rdata;
  logic               raw_re;
  logic [IDX_W-1:0]   raw_addr;
  logic [INSTR_W-1:0] raw_rdata;
  logic               dict_we;
  logic [IDX_W-1:0]   dict_waddr;
  logic [INSTR_W-1:0] dict_wdata;
  logic [CNT_W-1:0]   hit_count;
  logic [CNT_W-1:0]   miss_count;

  // Decompressor side.
  modport slave (
    input  req_valid, req_pc, resp_ready, code_rdata, raw_rdata,
           dict_we, dict_waddr, dict_wdata,
    output req_ready, resp_valid, resp_instr, resp_err, code_re, code_addr,
           raw_re, raw_addr, hit_count, miss_count
  );

  // Fetch stage / memories / loader side.
  modport master (
    output req_valid, req_pc, resp_ready, code_rdata, raw_rdata,
           dict_we, dict_waddr, dict_wdata,
    input  req_ready, resp_valid, resp_instr, resp_err, code_re, code_addr,
           raw_re, raw_addr, hit_count, miss_count
  );
endinterface

// File: rtl/dict_decompressor_dict.sv
// Dictionary register file: async clear, one sync write port, one comb read port.
// Indices at or beyond DICT_DEPTH are ignored on write and reported via rvalid on read.
module decomp_dict #(
  parameter int INSTR_W    = 32,
  parameter int IDX_W      = 8,
  parameter int DICT_DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [IDX_W-1:0]   raddr,
  output logic [INSTR_W-1:0] rdata,
  output logic               rvalid
);
  localparam int AW = (DICT_DEPTH > 1) ? $clog2(DICT_DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W+1)'(DICT_DEPTH);

  logic [INSTR_W-1:0] mem_q [DICT_DEPTH];
  logic [INSTR_W-1:0] mem_d [DICT_DEPTH];
  logic               waddr_ok;

  assign waddr_ok = ({1'b0, waddr} < DEPTH_LIM);
  assign rvalid   = ({1'b0, raddr} < DEPTH_LIM);
  assign rdata    = rvalid ? mem_q[raddr[AW-1:0]] : '0;

  // Next contents: only the addressed in-range entry changes.
  always_comb begin
    mem_d = mem_q;
    if (we && waddr_ok) mem_d[waddr[AW-1:0]] = wdata;
  end

  // Storage with asynchronous clear to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DICT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/dict_decompressor.sv
// Instruction decompressor: reads a code word per PC, expands it through the
// dictionary or fetches the full instruction from raw memory.
//
//   state       | meaning
//   ------------+----------------------------------------------------
//   ST_IDLE     | ready for a request, code_addr latched on accept
//   ST_CODE_RD  | code_re pulse for one cycle
//   ST_DECODE   | code word on code_rdata; dict expand, error, or raw
//   ST_RAW_RD   | raw_re pulse for one cycle
//   ST_RAW_WAIT | raw instruction on raw_rdata, captured
//   ST_RESP     | resp_valid held until resp_ready
module dict_decompressor
  import decomp_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int PC_W       = 32,
  parameter int IDX_W      = 8,
  parameter int DICT_DEPTH = 256
) (
  input logic               clk,
  input logic               rst_n,
  dict_decompressor_if.slave bus
);
  localparam int TAG_POS = code_tag_pos(IDX_W);
  localparam int IDX_MSB = code_idx_msb(IDX_W);

  decomp_state_t      state_q, state_d;
  decomp_kind_t       kind_q, kind_d;
  logic [PC_W-1:0]    code_addr_q, code_addr_d;
  logic [IDX_W-1:0]   raw_addr_q, raw_addr_d;
  logic [INSTR_W-1:0] resp_instr_q, resp_instr_d;
  logic               resp_err_q, resp_err_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic               code_tag;
  logic [IDX_W-1:0]   code_idx;
  logic [INSTR_W-1:0] dict_rdata;
  logic               dict_rvalid;

  assign code_tag = bus.code_rdata[TAG_POS];
  assign code_idx = bus.code_rdata[IDX_MSB:0];

  decomp_dict #(
    .INSTR_W    (INSTR_W),
    .IDX_W      (IDX_W),
    .DICT_DEPTH (DICT_DEPTH)
  ) u_dict (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (bus.dict_we),
    .waddr  (bus.dict_waddr),
    .wdata  (bus.dict_wdata),
    .raddr  (code_idx),
    .rdata  (dict_rdata),
    .rvalid (dict_rvalid)
  );

  // Next-state, capture registers and saturating counters.
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    code_addr_d  = code_addr_q;
    raw_addr_d   = raw_addr_q;
    resp_instr_d = resp_instr_q;
    resp_err_d   = resp_err_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          code_addr_d = bus.req_pc;
          state_d     = ST_CODE_RD;
        end
      end
      ST_CODE_RD: state_d = ST_DECODE;
      ST_DECODE: begin
        if (code_tag) begin
          // Read port sees pre-write contents, so a same-cycle write is not forwarded.
          if (dict_rvalid) begin
            resp_instr_d = dict_rdata;
            resp_err_d   = 1'b0;
            kind_d       = KIND_HIT;
          end else begin
            resp_instr_d = '0;
            resp_err_d   = 1'b1;
            kind_d       = KIND_ERR;
          end
          state_d = ST_RESP;
        end else begin
          raw_addr_d = code_idx;
          state_d    = ST_RAW_RD;
        end
      end
      ST_RAW_RD: state_d = ST_RAW_WAIT;
      ST_RAW_WAIT: begin
        resp_instr_d = bus.raw_rdata;
        resp_err_d   = 1'b0;
        kind_d       = KIND_RAW;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
          if (kind_q == KIND_HIT)      hit_cnt_d  = sat_inc(hit_cnt_q);
          else if (kind_q == KIND_RAW) miss_cnt_d = sat_inc(miss_cnt_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      kind_q       <= KIND_ERR;
      code_addr_q  <= '0;
      raw_addr_q   <= '0;
      resp_instr_q <= '0;
      resp_err_q   <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      code_addr_q  <= code_addr_d;
      raw_addr_q   <= raw_addr_d;
      resp_instr_q <= resp_instr_d;
      resp_err_q   <= resp_err_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Strobes decode straight from the state so reset removes them at once.
  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.code_re    = (state_q == ST_CODE_RD);
  assign bus.raw_re     = (state_q == ST_RAW_RD);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.code_addr  = code_addr_q;
  assign bus.raw_addr   = raw_addr_q;
  assign bus.resp_instr = resp_instr_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_dict_decompressor.sv
// Scoreboard bench for dict_decompressor with a 16-entry dictionary.
module tb_dict_decompressor;
  localparam int DEPTH = 16;
  localparam int K_ERR = 0, K_HIT = 1, K_RAW = 2;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          kind;
    int          lat;
    logic [7:0]  raw_addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dict_decompressor_if #(.INSTR_W(32), .PC_W(32), .IDX_W(8)) bus ();

  dict_decompressor #(
    .INSTR_W(32), .PC_W(32), .IDX_W(8), .DICT_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [8:0]  code_mem [256];
  logic [31:0] raw_mem  [256];
  logic [31:0] dict_m   [256];
  exp_t        sb [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          hit_m   = 0;
  int          miss_m  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Memories answer one cycle after their read strobe.
  always @(posedge clk) begin
    if (bus.code_re) bus.code_rdata <= code_mem[bus.code_addr[7:0]];
    if (bus.raw_re)  bus.raw_rdata  <= raw_mem[bus.raw_addr];
  end

  // Response monitor: compare on each handshake against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      chk("sb_size", 64'(sb.size()), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("resp_instr", 64'(bus.resp_instr), 64'(e.instr));
        chk("resp_err", 64'(bus.resp_err), 64'(e.err));
        if (e.kind == K_HIT) hit_m++;
        if (e.kind == K_RAW) miss_m++;
      end
    end
  end

  function automatic exp_t model(input logic [31:0] pc);
    exp_t e;
    logic [8:0] cw;
    cw = code_mem[pc[7:0]];
    e.raw_addr = 8'h00;
    if (cw[8]) begin
      e.lat = 3;
      if (int'(cw[7:0]) < DEPTH) begin
        e.instr = dict_m[cw[7:0]]; e.err = 1'b0; e.kind = K_HIT;
      end else begin
        e.instr = 32'h0; e.err = 1'b1; e.kind = K_ERR;
      end
    end else begin
      e.lat = 5; e.instr = raw_mem[cw[7:0]]; e.err = 1'b0; e.kind = K_RAW;
      e.raw_addr = cw[7:0];
    end
    return e;
  endfunction

  task automatic dict_write(input logic [7:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    bus.dict_we = 1'b1; bus.dict_waddr = idx; bus.dict_wdata = data;
    @(posedge clk); #1;
    bus.dict_we = 1'b0;
    dict_m[idx] = data;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  64'(bus.req_ready), 64'd1);
    chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, "_resp_instr"}, 64'(bus.resp_instr), 64'd0);
    chk({tag, "_resp_err"},   64'(bus.resp_err), 64'd0);
    chk({tag, "_code_re"},    64'(bus.code_re), 64'd0);
    chk({tag, "_code_addr"},  64'(bus.code_addr), 64'd0);
    chk({tag, "_raw_re"},     64'(bus.raw_re), 64'd0);
    chk({tag, "_raw_addr"},   64'(bus.raw_addr), 64'd0);
    chk({tag, "_hit"},        64'(bus.hit_count), 64'd0);
    chk({tag, "_miss"},       64'(bus.miss_count), 64'd0);
  endtask

  // One request; stall = cycles resp_ready is held low, wr_lat = cycle of an
  // injected dictionary write, rst_at = cycle at which reset is asserted.
  task automatic send_req(input logic [31:0] pc, input int stall, input int wr_lat,
                          input logic [7:0] wr_idx, input logic [31:0] wr_data,
                          input int rst_at);
    exp_t e;
    int lat, raw_lat;
    e = model(pc);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_pc = pc; bus.resp_ready = (stall == 0);
    sb.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_pc = '0;
    lat = 0; raw_lat = 0;
    while (lat < 20) begin
      @(negedge clk); lat++;
      if (lat == 1) begin
        chk("code_re", 64'(bus.code_re), 64'd1);
        chk("code_addr", 64'(bus.code_addr), 64'(pc));
      end
      if (lat > 1 && bus.code_re) chk("code_re_extra", 64'(lat), 64'd1);
      if (bus.raw_re) begin
        raw_lat = lat;
        chk("raw_addr", 64'(bus.raw_addr), 64'(e.raw_addr));
      end
      if (wr_lat > 0 && lat == wr_lat) begin
        bus.dict_we = 1'b1; bus.dict_waddr = wr_idx; bus.dict_wdata = wr_data;
      end
      if (wr_lat > 0 && lat == wr_lat + 1) begin
        bus.dict_we = 1'b0; dict_m[wr_idx] = wr_data;
      end
      if (lat == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        sb.delete(); hit_m = 0; miss_m = 0;
        for (int i = 0; i < 256; i++) dict_m[i] = 32'h0;
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      if (bus.resp_valid) break;
    end
    chk("resp_lat", 64'(lat), 64'(e.lat));
    chk("raw_re_lat", 64'(raw_lat), (e.kind == K_RAW) ? 64'd3 : 64'd0);
    if (!bus.resp_valid) begin
      sb.delete(); bus.resp_ready = 1'b0;
      return;
    end
    if (stall > 0) begin
      for (int k = 1; k < stall; k++) begin
        @(negedge clk);
        chk("stall_valid", 64'(bus.resp_valid), 64'd1);
        chk("stall_instr", 64'(bus.resp_instr), 64'(e.instr));
        chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
        chk("stall_code_re", 64'(bus.code_re), 64'd0);
      end
      @(posedge clk); #1;
      bus.resp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    chk("post_req_ready", 64'(bus.req_ready), 64'd1);
    chk("post_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("hit_count", 64'(bus.hit_count), 64'(hit_m));
    chk("miss_count", 64'(bus.miss_count), 64'(miss_m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      code_mem[i] = 9'h000; raw_mem[i] = 32'h0; dict_m[i] = 32'h0;
    end
    bus.req_valid = 1'b0; bus.req_pc = '0; bus.resp_ready = 1'b0;
    bus.dict_we = 1'b0; bus.dict_waddr = '0; bus.dict_wdata = '0;
    bus.code_rdata = '0; bus.raw_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    dict_write(8'd5, 32'h00A0_0093);
    code_mem[8'h10] = {1'b1, 8'h05};
    code_mem[8'h11] = {1'b0, 8'h22};
    raw_mem[8'h22]  = 32'hFE01_0113;
    code_mem[8'h12] = {1'b1, 8'h20};

    send_req(32'h10, 0, 0, 8'h0, 32'h0, 0);     // dictionary hit
    send_req(32'h11, 0, 0, 8'h0, 32'h0, 0);     // raw fetch
    send_req(32'h10, 4, 0, 8'h0, 32'h0, 0);     // consumer stall
    send_req(32'h12, 0, 0, 8'h0, 32'h0, 0);     // index beyond depth
    send_req(32'h10, 0, 2, 8'd5, 32'h1234_5678, 0); // write in DECODE: old value
    send_req(32'h10, 0, 0, 8'h0, 32'h0, 0);     // new value visible

    for (int i = 0; i < 4; i++) begin
      dict_write(8'(8 + i), $urandom);
      code_mem[8'h20 + 8'(i)] = {1'b1, 8'(8 + i)};
      code_mem[8'h30 + 8'(i)] = {1'b0, 8'h40 + 8'(i)};
      raw_mem[8'h40 + 8'(i)]  = $urandom;
      send_req(32'h20 + 32'(i), 0, 0, 8'h0, 32'h0, 0);
      send_req(32'h30 + 32'(i), i % 2, 0, 8'h0, 32'h0, 0);
    end
    code_mem[8'h13] = {1'b1, 8'h0F};
    send_req(32'h13, 0, 0, 8'h0, 32'h0, 0);     // last valid index

    send_req(32'h11, 0, 0, 8'h0, 32'h0, 4);     // reset in RAW_WAIT
    send_req(32'h11, 0, 0, 8'h0, 32'h0, 0);     // fresh request after reset

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dict_decompressor.md
# dict_decompressor

Sequential, parametrised instruction decompressor between the processor fetch stage and compressed program memory. For each requested PC it reads one code word, then either expands it through an internal loadable dictionary or fetches the full instruction from a raw-instruction memory. Requests and responses use valid/ready handshakes. Saturating hit/miss counters support compression-ratio measurements.

## Interface
- `INSTR_W`, 32, instruction width.
- `PC_W`, 32, request PC and code-memory address width.
- `IDX_W`, 8, index field width; the code word is `CODE_W = IDX_W + 1` bits.
- `DICT_DEPTH`, 256, number of dictionary entries; must be ≤ 2**`IDX_W`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: fetch request present.
- `req_ready` out 1: block can accept a request.
- `req_pc` in `PC_W`: requested PC.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_instr` out `INSTR_W`: decompressed instruction.
- `resp_err` out 1: dictionary index was out of range.
- `code_re` out 1: code-memory read strobe.
- `code_addr` out `PC_W`: code-memory address.
- `code_rdata` in `CODE_W`: code word, valid the cycle after `code_re`.
- `raw_re` out 1: raw-memory read strobe.
- `raw_addr` out `IDX_W`: raw-memory address.
- `raw_rdata` in `INSTR_W`: raw instruction, valid the cycle after `raw_re`.
- `dict_we` in 1: dictionary write enable.
- `dict_waddr` in `IDX_W`: dictionary write index.
- `dict_wdata` in `INSTR_W`: dictionary write data.
- `hit_count` out 32: saturating count of dictionary-expanded responses.
- `miss_count` out 32: saturating count of raw-fetched responses.

## Operation
- Code word format:
  - bit `IDX_W` = 1: dictionary hit, low `IDX_W` bits are the dictionary index.
  - bit `IDX_W` = 0: raw, low bits are the raw-memory address.
- FSM states: IDLE, CODE_RD, DECODE, RAW_RD, RAW_WAIT, RESP.
  - IDLE: `req_ready` = 1. On `req_valid`, register `code_addr` = `req_pc` and go to CODE_RD.
  - CODE_RD: `code_re` = 1 for exactly one cycle, then go to DECODE.
  - DECODE: sample `code_rdata`.
    - Hit with index < `DICT_DEPTH`: `resp_instr` ← dict[idx], `resp_err` ← 0, go to RESP.
    - Hit with index ≥ `DICT_DEPTH`: `resp_instr` ← 0, `resp_err` ← 1, go to RESP; neither counter changes.
    - Raw: `raw_addr` ← idx, go to RAW_RD.
  - RAW_RD: `raw_re` = 1 for one cycle, then go to RAW_WAIT.
  - RAW_WAIT: `resp_instr` ← `raw_rdata`, `resp_err` ← 0, go to RESP.
  - RESP: `resp_valid` = 1. Hold `resp_instr` and `resp_err` stable until `resp_ready`, then go to IDLE.
- Counters update on the response handshake cycle. They saturate at 0xFFFF_FFFF and do not wrap.
- Dictionary writes are accepted in any state and take effect at the next edge.
  - A DECODE read of the same index in the write cycle returns the old value.
- Only one request is outstanding at a time. `req_ready` = 0 outside IDLE.

## Timing
- Request accepted at edge N.
- Dictionary hit: `code_re` high in cycle N+1; `resp_valid` high from cycle N+3.
- Raw: `raw_re` high in cycle N+3; `resp_valid` high from cycle N+5.
- Back-to-back: if `resp_ready` = 1 in the first `resp_valid` cycle, the next request can be accepted one cycle later.
- Reset values: all outputs 0, `req_ready` 1 (state IDLE), counters 0, dictionary entries 0.
- Reset mid-operation: the FSM returns to IDLE immediately.
  - Any in-flight response is dropped.
  - Strobes deassert asynchronously.

## Structure
- Package `decomp_pkg` holds:
  - the state enum `decomp_state_t`;
  - code-word field positions (tag bit, index slice) as parameters/functions of `IDX_W`;
  - the counter width constant (32).
- Sub-module `decomp_dict`: `DICT_DEPTH` × `INSTR_W` register file with async-reset clear, one synchronous write port and one combinational read port.
- The top contains the FSM, memory-port registers and counters.

## Test plan
- Load dict[5] = 0x00A0_0093; code memory at PC 0x10 = {1, 0x05}; request PC 0x10 with `resp_ready` = 1 → `resp_valid` at N+3, `resp_instr` = 0x00A0_0093, `resp_err` = 0, `hit_count` = 1.
- Code at PC 0x11 = {0, 0x22}; raw[0x22] = 0xFE01_0113 → `raw_addr` = 0x22 with `raw_re` at N+3, `resp_instr` = 0xFE01_0113 at N+5, `miss_count` = 1.
- `resp_ready` held 0 for 4 cycles → `resp_valid` and `resp_instr` stable, `req_ready` = 0, no extra `code_re`. Release → IDLE the next cycle.
- `DICT_DEPTH` = 16, code word {1, 0x20} → `resp_err` = 1, `resp_instr` = 0, both counters unchanged.
- `dict_we` to index 5 with new value in the DECODE cycle of a hit on index 5 → old value returned; a repeat request returns the new value.
- `rst_n` asserted in RAW_WAIT → all outputs 0 and counters 0 immediately. After release, `req_ready` = 1 and a fresh request completes normally.
